apb2axi_req_sched: RTL and testbench
====================================

APB2AXI_REQ_SCHED -- requirements
Module: apb2axi_req_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CMD_ENTRY_W, 64, width of a packed command entry.
- MAX_OST, 4, maximum outstanding transactions per direction, legal range 1..15.
- OST_W, 4, width of each outstanding counter; SHALL be >= clog2(MAX_OST+1).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- aclk, in, 1, single clock; all logic is on its rising edge.
- aresetn, in, 1, reset, synchronous, active-low.
- wr_pop_vld, in, 1, WR request FIFO is non-empty.
- wr_pop_data, in, CMD_ENTRY_W, head entry of the WR request FIFO.
- wr_pop_rdy, out, 1, pop strobe to the WR request FIFO.
- rd_pop_vld, in, 1, RD request FIFO is non-empty.
- rd_pop_data, in, CMD_ENTRY_W, head entry of the RD request FIFO.
- rd_pop_rdy, out, 1, pop strobe to the RD request FIFO.
- issue_vld, out, 1, command valid toward the AXI master front end.
- issue_is_write, out, 1, 1 = write command, 0 = read command.
- issue_data, out, CMD_ENTRY_W, command entry being issued.
- issue_rdy, in, 1, AXI master front end accepts the command.
- wr_done, in, 1, one-cycle pulse per completed write (B handshake).
- rd_done, in, 1, one-cycle pulse per completed read (last R beat).
- hold, in, 1, while high, no new pops are started (drain request).
- wr_ost, out, OST_W, current outstanding write count.
- rd_ost, out, OST_W, current outstanding read count.
- idle, out, 1, high when nothing is held or outstanding.
- ost_err, out, 1, sticky flag set when a done pulse arrives while its counter is 0.

Function
REQ-003 The block SHALL implement a two-state FSM: SEL and ISSUE.

REQ-004 In SEL, a direction SHALL be eligible when its pop_vld = 1, its counter < MAX_OST, and hold = 0.

REQ-005 In SEL, if exactly one direction is eligible, it SHALL be granted.

REQ-006 In SEL, if both directions are eligible, the direction opposite to last_grant SHALL be granted (round-robin).

REQ-007 On a grant, the block SHALL:
- assert the granted pop_rdy combinationally for exactly that cycle;
- register the pop_data into issue_data and set issue_is_write;
- update last_grant to the granted direction;
- move to ISSUE.

REQ-008 wr_pop_rdy and rd_pop_rdy SHALL never both be high, and SHALL never be high outside SEL.

REQ-009 In ISSUE, issue_vld SHALL be 1.
- issue_data and issue_is_write SHALL stay stable until the cycle with issue_vld && issue_rdy.
- On that handshake, the FSM SHALL return to SEL on the next cycle.

REQ-010 Minimum spacing between pops SHALL be 2 cycles; pop-to-issue_vld latency SHALL be 1 cycle.

REQ-011 On the issue handshake, the counter of the issued direction SHALL increment by 1.

REQ-012 A done pulse SHALL decrement the counter of its own direction by 1.

REQ-013 If an increment and a decrement of the same counter occur in the same cycle, the counter SHALL be unchanged.

REQ-014 A done pulse arriving while its counter is 0 SHALL:
- leave the counter at 0 (no wrap);
- set ost_err, which stays set until reset.

REQ-015 A counter SHALL never exceed MAX_OST; by REQ-004, a direction at MAX_OST is not granted until it receives a done pulse.

REQ-016 idle SHALL be 1 iff FSM = SEL, wr_ost = 0, and rd_ost = 0.

REQ-017 hold SHALL NOT affect a command already in ISSUE; it only blocks new grants.

REQ-018 When issue_vld is 0, issue_data and issue_is_write SHALL be 0.

Reset
REQ-019 When aresetn = 0 at a rising edge, the block SHALL set:
- FSM = SEL;
- wr_ost = 0 and rd_ost = 0;
- ost_err = 0;
- last_grant = RD, so the first tie goes to WR;
- issue_vld = 0, issue_data = 0, issue_is_write = 0.

REQ-020 While aresetn = 0, wr_pop_rdy and rd_pop_rdy SHALL be 0.

REQ-021 Reset asserted during ISSUE SHALL discard the held command; no counter update occurs for it.

Verification
REQ-022 Tie: both FIFOs hold 3 entries, issue_rdy = 1, no done pulses -> issue order W,R,W,R,W,R, one pop every 2 cycles, final wr_ost = 3 and rd_ost = 3.

REQ-023 Limit: MAX_OST = 4, 6 reads queued, no rd_done -> exactly 4 reads issued and rd_pop_rdy stays 0; one rd_done pulse -> 5th read pops on the next SEL cycle.

REQ-024 Backpressure: issue_rdy = 0 for 5 cycles in ISSUE -> issue_vld stays 1 with issue_data unchanged, no second pop occurs, and the counter increments only on the handshake cycle.

REQ-025 Simultaneous events: with wr_ost = 2, a write issue handshake and wr_done occur in the same cycle -> wr_ost remains 2; a rd_done pulse with rd_ost = 0 -> rd_ost stays 0 and ost_err = 1.

REQ-026 Hold and reset: hold = 1 with both FIFOs non-empty -> no pops and idle = 1 once the counters drain; aresetn = 0 while in ISSUE -> next cycle issue_vld = 0, wr_ost = 0, rd_ost = 0, and the first tie after reset grants WR.

Source files
------------

// File: rtl/apb2axi_req_sched.sv
// APB-to-AXI request scheduler: round-robin pop of WR/RD command
// FIFOs with per-direction outstanding limits and issue handshake.
module apb2axi_req_sched #(
  parameter int CMD_ENTRY_W = 64,
  parameter int MAX_OST     = 4,
  parameter int OST_W       = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   wr_pop_vld,
  input  logic [CMD_ENTRY_W-1:0] wr_pop_data,
  output logic                   wr_pop_rdy,
  input  logic                   rd_pop_vld,
  input  logic [CMD_ENTRY_W-1:0] rd_pop_data,
  output logic                   rd_pop_rdy,
  output logic                   issue_vld,
  output logic                   issue_is_write,
  output logic [CMD_ENTRY_W-1:0] issue_data,
  input  logic                   issue_rdy,
  input  logic                   wr_done,
  input  logic                   rd_done,
  input  logic                   hold,
  output logic [OST_W-1:0]       wr_ost,
  output logic [OST_W-1:0]       rd_ost,
  output logic                   idle,
  output logic                   ost_err
);

  typedef enum logic {SEL, ISSUE} state_t;

  state_t                 state_q, state_d;
  logic                   last_wr_q;
  logic                   is_wr_q;
  logic [CMD_ENTRY_W-1:0] data_q;
  logic [OST_W-1:0]       wr_ost_q, wr_ost_d;
  logic [OST_W-1:0]       rd_ost_q, rd_ost_d;
  logic                   ost_err_q;

  logic wr_elig, rd_elig;
  logic issue_hs;
  logic wr_inc, rd_inc;

  assign wr_elig = wr_pop_vld && !hold &&
                   (wr_ost_q < OST_W'(MAX_OST));
  assign rd_elig = rd_pop_vld && !hold &&
                   (rd_ost_q < OST_W'(MAX_OST));

  assign issue_vld = (state_q == ISSUE);
  assign issue_hs  = issue_vld && issue_rdy;
  assign wr_inc    = issue_hs && is_wr_q;
  assign rd_inc    = issue_hs && !is_wr_q;

  always_comb begin
    state_d    = state_q;
    wr_pop_rdy = 1'b0;
    rd_pop_rdy = 1'b0;
    unique case (state_q)
      SEL: begin
        if (aresetn) begin
          // on a tie, the side that did not win last time goes
          wr_pop_rdy = wr_elig && (!rd_elig || !last_wr_q);
          rd_pop_rdy = rd_elig && (!wr_elig || last_wr_q);
        end
        if (wr_pop_rdy || rd_pop_rdy)
          state_d = ISSUE;
      end
      ISSUE: begin
        if (issue_rdy)
          state_d = SEL;
      end
      default: state_d = SEL;
    endcase
  end

  always_comb begin
    wr_ost_d = wr_ost_q;
    if (wr_inc && !wr_done)
      wr_ost_d = wr_ost_q + OST_W'(1);
    else if (!wr_inc && wr_done && wr_ost_q != '0)
      wr_ost_d = wr_ost_q - OST_W'(1);
  end

  always_comb begin
    rd_ost_d = rd_ost_q;
    if (rd_inc && !rd_done)
      rd_ost_d = rd_ost_q + OST_W'(1);
    else if (!rd_inc && rd_done && rd_ost_q != '0)
      rd_ost_d = rd_ost_q - OST_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= SEL;
      last_wr_q <= 1'b0;
      is_wr_q   <= 1'b0;
      data_q    <= '0;
      wr_ost_q  <= '0;
      rd_ost_q  <= '0;
      ost_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ost_q <= wr_ost_d;
      rd_ost_q <= rd_ost_d;
      if (wr_pop_rdy) begin
        data_q    <= wr_pop_data;
        is_wr_q   <= 1'b1;
        last_wr_q <= 1'b1;
      end else if (rd_pop_rdy) begin
        data_q    <= rd_pop_data;
        is_wr_q   <= 1'b0;
        last_wr_q <= 1'b0;
      end else if (issue_hs) begin
        data_q  <= '0;
        is_wr_q <= 1'b0;
      end
      // a completion with nothing outstanding is a protocol error
      if ((wr_done && wr_ost_q == '0) ||
          (rd_done && rd_ost_q == '0))
        ost_err_q <= 1'b1;
    end
  end

  assign issue_data     = data_q;
  assign issue_is_write = is_wr_q;
  assign wr_ost         = wr_ost_q;
  assign rd_ost         = rd_ost_q;
  assign ost_err        = ost_err_q;
  assign idle           = (state_q == SEL) &&
                          (wr_ost_q == '0) &&
                          (rd_ost_q == '0);

endmodule

// File: tb/tb_apb2axi_req_sched.sv
// Directed bench for apb2axi_req_sched: tie order, limit,
// backpressure, simultaneous inc/dec, hold and reset.
module tb_apb2axi_req_sched;

  localparam int W = 64;

  logic         aclk;
  logic         aresetn;
  logic         wr_pop_vld;
  logic [W-1:0] wr_pop_data;
  logic         wr_pop_rdy;
  logic         rd_pop_vld;
  logic [W-1:0] rd_pop_data;
  logic         rd_pop_rdy;
  logic         issue_vld;
  logic         issue_is_write;
  logic [W-1:0] issue_data;
  logic         issue_rdy;
  logic         wr_done;
  logic         rd_done;
  logic         hold;
  logic [3:0]   wr_ost;
  logic [3:0]   rd_ost;
  logic         idle;
  logic         ost_err;

  apb2axi_req_sched #(
    .CMD_ENTRY_W(W),
    .MAX_OST(4),
    .OST_W(4)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .wr_pop_vld(wr_pop_vld),
    .wr_pop_data(wr_pop_data),
    .wr_pop_rdy(wr_pop_rdy),
    .rd_pop_vld(rd_pop_vld),
    .rd_pop_data(rd_pop_data),
    .rd_pop_rdy(rd_pop_rdy),
    .issue_vld(issue_vld),
    .issue_is_write(issue_is_write),
    .issue_data(issue_data),
    .issue_rdy(issue_rdy),
    .wr_done(wr_done),
    .rd_done(rd_done),
    .hold(hold),
    .wr_ost(wr_ost),
    .rd_ost(rd_ost),
    .idle(idle),
    .ost_err(ost_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // request FIFO models
  logic [W-1:0] wr_mem [16];
  logic [W-1:0] rd_mem [16];
  int wr_head = 0, wr_tail = 0;
  int rd_head = 0, rd_tail = 0;

  assign wr_pop_vld  = (wr_head != wr_tail);
  assign rd_pop_vld  = (rd_head != rd_tail);
  assign wr_pop_data = wr_mem[wr_head[3:0]];
  assign rd_pop_data = rd_mem[rd_head[3:0]];

  int cyc_n = 0;
  int pops = 0;
  int pop_cyc [32];
  int n_iss = 0;
  logic         log_w [32];
  logic [W-1:0] log_d [32];

  always @(posedge aclk) begin
    cyc_n <= cyc_n + 1;
    if (wr_pop_rdy) wr_head <= wr_head + 1;
    if (rd_pop_rdy) rd_head <= rd_head + 1;
    if (wr_pop_rdy || rd_pop_rdy) begin
      pop_cyc[pops] <= cyc_n;
      pops <= pops + 1;
    end
    if (aresetn && issue_vld && issue_rdy) begin
      log_w[n_iss] <= issue_is_write;
      log_d[n_iss] <= issue_data;
      n_iss <= n_iss + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_wr;
    wr_tail = wr_tail + 1;
  endtask

  task automatic push_rd;
    rd_tail = rd_tail + 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      wr_mem[i] = 64'hA0A0_0000_0000_0000 | 64'(i + 1);
      rd_mem[i] = 64'hB0B0_0000_0000_0000 | 64'(i + 1);
    end
    aresetn   = 1'b0;
    issue_rdy = 1'b1;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    hold      = 1'b0;
    repeat (3) push_wr;
    repeat (3) push_rd;
    cyc(2);

    // reset state
    chk("rst_vld", 64'(issue_vld), 64'd0);
    chk("rst_data", issue_data, 64'd0);
    chk("rst_isw", 64'(issue_is_write), 64'd0);
    chk("rst_wost", 64'(wr_ost), 64'd0);
    chk("rst_rost", 64'(rd_ost), 64'd0);
    chk("rst_err", 64'(ost_err), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_wpop", 64'(wr_pop_rdy), 64'd0);
    chk("rst_rpop", 64'(rd_pop_rdy), 64'd0);

    // tie: W first, alternate
    aresetn = 1'b1;
    #1;
    chk("tie_wpop", 64'(wr_pop_rdy), 64'd1);
    chk("tie_rpop", 64'(rd_pop_rdy), 64'd0);
    cyc(1);
    chk("tie_vld", 64'(issue_vld), 64'd1);
    chk("tie_isw", 64'(issue_is_write), 64'd1);
    chk("tie_d0", issue_data, wr_mem[0]);
    chk("tie_nopop", 64'(wr_pop_rdy | rd_pop_rdy), 64'd0);
    cyc(11);
    chk("tie_niss", 64'(n_iss), 64'd6);
    chk("tie_pops", 64'(pops), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("tie_ordw", 64'(log_w[i]), 64'(i % 2 == 0));
      chk("tie_ordd", log_d[i],
          (i % 2 == 0) ? wr_mem[i/2] : rd_mem[i/2]);
    end
    for (int i = 1; i < 6; i++)
      chk("tie_space", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd2);
    chk("tie_wost", 64'(wr_ost), 64'd3);
    chk("tie_rost", 64'(rd_ost), 64'd3);
    chk("tie_vld0", 64'(issue_vld), 64'd0);
    chk("tie_dat0", issue_data, 64'd0);

    // backpressure then simultaneous inc/dec
    wr_done = 1'b1;
    cyc(1);
    wr_done = 1'b0;
    chk("bp_wost2", 64'(wr_ost), 64'd2);
    issue_rdy = 1'b0;
    push_wr;
    cyc(1);
    push_wr;
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 64'(issue_vld), 64'd1);
      chk("bp_data", issue_data, wr_mem[3]);
      chk("bp_wost", 64'(wr_ost), 64'd2);
      chk("bp_pops", 64'(pops), 64'd7);
      chk("bp_wpop", 64'(wr_pop_rdy), 64'd0);
      cyc(1);
    end
    issue_rdy = 1'b1;
    wr_done   = 1'b1;
    cyc(1);
    wr_done = 1'b0;
    chk("sim_wost", 64'(wr_ost), 64'd2);
    chk("sim_vld", 64'(issue_vld), 64'd0);
    chk("sim_niss", 64'(n_iss), 64'd7);
    chk("sim_wpop", 64'(wr_pop_rdy), 64'd1);
    cyc(2);
    chk("sim_wost3", 64'(wr_ost), 64'd3);
    chk("sim_log7", log_d[7], wr_mem[4]);

    // hold blocks pops while counters drain
    hold = 1'b1;
    repeat (6) push_rd;
    push_wr;
    wr_done = 1'b1;
    rd_done = 1'b1;
    cyc(3);
    wr_done = 1'b0;
    rd_done = 1'b0;
    cyc(2);
    chk("hold_idle", 64'(idle), 64'd1);
    chk("hold_wost", 64'(wr_ost), 64'd0);
    chk("hold_rost", 64'(rd_ost), 64'd0);
    chk("hold_pops", 64'(pops), 64'd8);
    chk("hold_wpop", 64'(wr_pop_rdy), 64'd0);
    chk("hold_rpop", 64'(rd_pop_rdy), 64'd0);
    chk("hold_err", 64'(ost_err), 64'd0);

    // limit: reads stop at 4 outstanding
    hold = 1'b0;
    #1;
    chk("lim_rr", 64'(rd_pop_rdy), 64'd1);
    cyc(10);
    chk("lim_rost", 64'(rd_ost), 64'd4);
    chk("lim_wost", 64'(wr_ost), 64'd1);
    chk("lim_niss", 64'(n_iss), 64'd13);
    chk("lim_l8", log_d[8], rd_mem[3]);
    chk("lim_l9", log_d[9], wr_mem[5]);
    chk("lim_l10", log_d[10], rd_mem[4]);
    chk("lim_l11", log_d[11], rd_mem[5]);
    chk("lim_l12", log_d[12], rd_mem[6]);
    for (int i = 0; i < 3; i++) begin
      chk("lim_rpop", 64'(rd_pop_rdy), 64'd0);
      chk("lim_vld", 64'(issue_vld), 64'd0);
      cyc(1);
    end
    chk("lim_rost2", 64'(rd_ost), 64'd4);
    rd_done = 1'b1;
    cyc(1);
    rd_done = 1'b0;
    chk("lim_dec", 64'(rd_ost), 64'd3);
    chk("lim_pop5", 64'(rd_pop_rdy), 64'd1);
    issue_rdy = 1'b0;
    cyc(1);
    chk("lim_vld5", 64'(issue_vld), 64'd1);
    chk("lim_isw5", 64'(issue_is_write), 64'd0);
    chk("lim_dat5", issue_data, rd_mem[7]);

    // reset while in ISSUE
    aresetn = 1'b0;
    #1;
    chk("ri_wpop", 64'(wr_pop_rdy), 64'd0);
    chk("ri_rpop", 64'(rd_pop_rdy), 64'd0);
    cyc(1);
    chk("ri_vld", 64'(issue_vld), 64'd0);
    chk("ri_data", issue_data, 64'd0);
    chk("ri_wost", 64'(wr_ost), 64'd0);
    chk("ri_rost", 64'(rd_ost), 64'd0);
    chk("ri_niss", 64'(n_iss), 64'd13);
    push_wr;
    aresetn   = 1'b1;
    issue_rdy = 1'b1;
    #1;
    chk("ri_tie_w", 64'(wr_pop_rdy), 64'd1);
    chk("ri_tie_r", 64'(rd_pop_rdy), 64'd0);

    // done with nothing outstanding
    rd_done = 1'b1;
    cyc(1);
    rd_done = 1'b0;
    chk("err_rost", 64'(rd_ost), 64'd0);
    chk("err_flag", 64'(ost_err), 64'd1);
    cyc(4);
    chk("err_stick", 64'(ost_err), 64'd1);
    chk("end_wost", 64'(wr_ost), 64'd1);
    chk("end_rost", 64'(rd_ost), 64'd1);
    chk("end_niss", 64'(n_iss), 64'd15);
    chk("end_l13", log_d[13], wr_mem[6]);
    chk("end_l14", log_d[14], rd_mem[8]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
